// File: rtl/commit_trace_if.sv
// commit_trace_if: commit-side producer and trace-side consumer signals for commit_trace_fifo.
// Optional trace_cycle stamp port exists only when COMMIT_TRACE_CYCLE_STAMP_EN is defined.
interface commit_trace_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    logic                     commit_en;
    logic [31:0]              commit_pc;
    logic [31:0]              commit_instr;
    logic                     flush;
    logic                     trace_valid;
    logic                     trace_ready;
    logic [31:0]              trace_pc;
    logic [31:0]              trace_instr;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [CNT_W-1:0]         drop_cnt;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    logic [31:0]              trace_cycle;
    modport master (output commit_en, commit_pc, commit_instr, flush, trace_ready,
                    input trace_valid, trace_pc, trace_instr, count, overflow, drop_cnt, trace_cycle);
    modport slave  (input commit_en, commit_pc, commit_instr, flush, trace_ready,
                    output trace_valid, trace_pc, trace_instr, count, overflow, drop_cnt, trace_cycle);
`else
    modport master (output commit_en, commit_pc, commit_instr, flush, trace_ready,
                    input trace_valid, trace_pc, trace_instr, count, overflow, drop_cnt);
    modport slave  (input commit_en, commit_pc, commit_instr, flush, trace_ready,
                    output trace_valid, trace_pc, trace_instr, count, overflow, drop_cnt);
`endif
endinterface

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: buffers retired {pc, instr} pairs for a trace consumer, counting dropped commits.
// Define COMMIT_TRACE_CYCLE_STAMP_EN to stamp each entry with a free-running cycle counter.
module commit_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    commit_trace_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             ovf;
    logic [CNT_W-1:0] drops;
    logic             push, pop, drop;

    assign bus.trace_valid = cnt != '0;
    assign pop  = bus.trace_valid && bus.trace_ready;
    assign push = bus.commit_en && (cnt != FULL || pop);
    // a commit swallowed by flush is discarded, not counted as dropped
    assign drop = bus.commit_en && cnt == FULL && !pop && !bus.flush;

    assign bus.trace_pc    = pc_mem[rd_ptr];
    assign bus.trace_instr = instr_mem[rd_ptr];
    assign bus.count       = cnt;
    assign bus.overflow    = ovf;
    assign bus.drop_cnt    = drops;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.commit_pc;
            instr_mem[wr_ptr] <= bus.commit_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            drops  <= '0;
        end else begin
            if (bus.flush) begin
                cnt    <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
            if (drop) begin
                ovf <= 1'b1;
                if (~&drops) drops <= drops + CNT_W'(1);
            end
        end
    end

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    logic [31:0] cyc;
    logic [31:0] cyc_mem [DEPTH];

    always_ff @(posedge clk) begin
        cyc <= rst ? 32'd0 : cyc + 32'd1;
        if (push) cyc_mem[wr_ptr] <= cyc;
    end

    assign bus.trace_cycle = cyc_mem[rd_ptr];
`endif
endmodule
